// File: rtl/regfile_pkg.sv
// Shared definitions for the clearable register file: FSM state encoding
// and the default word width / depth.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam int N_DEFAULT     = 8;
  localparam int DEPTH_DEFAULT = 8;

endpackage

// File: rtl/regfile_clr.sv
// regfile_clr: DEPTH x N register file with two combinational read ports,
// one write port and a multi-cycle clear sweep that zeroes every entry and
// marks it valid, one entry per clock.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> write-first forwarding: a read of the address being written
//                in this cycle returns the incoming data with valid=1.
//   undefined -> read-first: reads show the pre-write contents until the edge.
//
// Handshake: enable and clear are single-cycle request strobes sampled on the
// rising edge of clock. There is no ready/acknowledge; busy=1 means every
// request presented in that cycle is dropped (no queuing), and busy=0 means
// a request is accepted at the next edge. clear wins over enable.
//
// dbg_state exposes the FSM state register for checkers.
module regfile_clr
  import regfile_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [N-1:0]  in,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [AW-1:0] addr3,
  input  logic          enable,
  input  logic          clear,
  output logic [N-1:0]  z1,
  output logic [N-1:0]  z2,
  output logic          v1,
  output logic          v2,
  output logic          busy,
  output logic          dbg_state
);

  // One extra bit so DEPTH itself (e.g. 256) is representable in compares.
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t          state;
  logic [AW-1:0]   ptr;
  logic [DEPTH-1:0] valid;
  logic [N-1:0]    mem [DEPTH];

  logic            do_write;
  logic            in_range1;
  logic            in_range2;

  // A write lands only in IDLE, without a concurrent clear, to a real entry.
  assign do_write  = (state == IDLE) && enable && !clear && ({1'b0, addr3} < DEPTH_W);
  assign in_range1 = ({1'b0, addr1} < DEPTH_W);
  assign in_range2 = ({1'b0, addr2} < DEPTH_W);

  assign busy      = (state == SWEEP);
  assign dbg_state = state;

  // Control state: FSM, sweep pointer and valid bits; reset clears all of it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= '0;
      valid <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            state <= SWEEP;
            ptr   <= '0;
          end else if (do_write) begin
            valid[addr3] <= 1'b1;
          end
        end
        SWEEP: begin
          valid[ptr] <= 1'b1;
          if (ptr == LAST) begin
            state <= IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ptr   <= '0;
        end
      endcase
    end
  end

  // Data array: no reset so it can map onto RAM/LUT storage.
  always_ff @(posedge clock) begin
    if (state == SWEEP) begin
      mem[ptr] <= '0;
    end else if (do_write) begin
      mem[addr3] <= in;
    end
  end

  // Read port 1: invalid or out-of-range entries read as zero.
  always_comb begin
    z1 = '0;
    v1 = 1'b0;
    if (in_range1 && valid[addr1]) begin
      z1 = mem[addr1];
      v1 = 1'b1;
    end
`ifdef REGFILE_BYPASS_EN
    if (do_write && (addr3 == addr1)) begin
      z1 = in;
      v1 = 1'b1;
    end
`endif
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    z2 = '0;
    v2 = 1'b0;
    if (in_range2 && valid[addr2]) begin
      z2 = mem[addr2];
      v2 = 1'b1;
    end
`ifdef REGFILE_BYPASS_EN
    if (do_write && (addr3 == addr2)) begin
      z2 = in;
      v2 = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_clr.sv
// Testbench for regfile_clr at DEPTH=6 (non power of two, so addresses 6 and
// 7 are out of range). A behavioural model predicts each read; predictions
// are queued when stimulus is applied and popped when the outputs settle.
module tb_regfile_clr;

  localparam int N     = 8;
  localparam int DEPTH = 6;
  localparam int AW    = 3;
  localparam int W     = N + 1;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [N-1:0]  in;
  logic [AW-1:0] addr1, addr2, addr3;
  logic          enable, clear;
  logic [N-1:0]  z1, z2;
  logic          v1, v2, busy, dbg_state;

  // model state
  logic [N-1:0]  m_mem [DEPTH];
  logic          m_valid [DEPTH];
  logic          m_busy;
  int            m_ptr;

  logic [W-1:0]  exp_q [$];
  logic [W-1:0]  got, exp;
  int            checks = 0;
  int            errors = 0;
  int            busy_cycles;

  regfile_clr #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .reset_n(reset_n), .in(in),
    .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .enable(enable), .clear(clear),
    .z1(z1), .z2(z2), .v1(v1), .v2(v2),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_busy = 1'b0;
    m_ptr  = 0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  function automatic logic [W-1:0] model_read(int a);
    logic [W-1:0] r;
    r = '0;
    if (a < DEPTH && m_valid[a]) r = {1'b1, m_mem[a]};
`ifdef REGFILE_BYPASS_EN
    if (!m_busy && enable && !clear && int'(addr3) == a && a < DEPTH) r = {1'b1, in};
`endif
    return r;
  endfunction

  // Advance the model by one edge using the currently driven inputs, then
  // move to 1 time unit past the next rising edge.
  task automatic tick();
    if (!m_busy) begin
      if (clear) begin
        m_busy = 1'b1;
        m_ptr  = 0;
      end else if (enable && int'(addr3) < DEPTH) begin
        m_mem[addr3]   = in;
        m_valid[addr3] = 1'b1;
      end
    end else begin
      m_mem[m_ptr]   = '0;
      m_valid[m_ptr] = 1'b1;
      if (m_ptr == DEPTH - 1) begin
        m_busy = 1'b0;
        m_ptr  = 0;
      end else begin
        m_ptr++;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic push_reads();
    exp_q.push_back(model_read(int'(addr1)));
    exp_q.push_back(model_read(int'(addr2)));
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; clear = 1'b0;
    in = '0; addr1 = 3'd3; addr2 = 3'd5; addr3 = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    push_reads();
    #2;
    for (int p = 0; p < 2; p++) begin
      got = (p == 0) ? {v1, z1} : {v2, z2};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_read port%0d got=%h exp=%h", p + 1, got, exp); end
    end
    checks++;
    if (busy !== 1'b0 || dbg_state !== 1'b0) begin
      errors++; $display("FAIL reset_busy got busy=%b state=%b exp 0/0", busy, dbg_state);
    end
  endtask

  task automatic test_write();
    addr3 = 3'd2; in = 8'hA5; enable = 1'b1; addr1 = 3'd2; addr2 = 3'd2;
    for (int c = 0; c < 2; c++) begin
      push_reads();
      #2;
      for (int p = 0; p < 2; p++) begin
        got = (p == 0) ? {v1, z1} : {v2, z2};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL write cyc%0d port%0d got=%h exp=%h", c, p + 1, got, exp); end
      end
      tick();
      enable = 1'b0;
    end
  endtask

  task automatic test_out_of_range();
    addr3 = 3'd7; in = 8'h55; enable = 1'b1; addr1 = 3'd7; addr2 = 3'd6;
    tick();
    enable = 1'b0;
    for (int a = 0; a < 8; a += 2) begin
      addr1 = AW'(a); addr2 = AW'(a + 1);
      push_reads();
      #2;
      for (int p = 0; p < 2; p++) begin
        got = (p == 0) ? {v1, z1} : {v2, z2};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL oob addr=%0d got=%h exp=%h", a + p, got, exp); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      enable = 1'($urandom_range(0, 1));
      addr3  = AW'($urandom_range(0, 7));
      in     = N'($urandom_range(0, 255));
      addr1  = AW'($urandom_range(0, 7));
      addr2  = (i % 4 == 0) ? addr3 : AW'($urandom_range(0, 7));
      push_reads();
      #2;
      for (int p = 0; p < 2; p++) begin
        got = (p == 0) ? {v1, z1} : {v2, z2};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL random it%0d port%0d got=%h exp=%h", i, p + 1, got, exp); end
      end
      tick();
    end
    enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    enable = 1'b1;
    for (int a = 0; a <= DEPTH; a++) begin
      enable = (a < DEPTH);
      addr3  = AW'(a % DEPTH);
      in     = N'(a * 17 + 3);
      addr1  = AW'((a + DEPTH - 1) % DEPTH);
      addr2  = AW'(a % DEPTH);
      push_reads();
      #2;
      for (int p = 0; p < 2; p++) begin
        got = (p == 0) ? {v1, z1} : {v2, z2};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL b2b a=%0d port%0d got=%h exp=%h", a, p + 1, got, exp); end
      end
      tick();
    end
    enable = 1'b0;
  endtask

  task automatic test_sweep();
    enable = 1'b1; in = 8'hFF;
    for (int a = 0; a < DEPTH; a++) begin addr3 = AW'(a); tick(); end
    // clear together with enable: the write must be dropped
    clear = 1'b1; enable = 1'b1; addr3 = 3'd0; in = 8'h11;
    tick();
    clear = 1'b0; enable = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 2 * DEPTH; c++) begin
      enable = (c == 1); clear = (c == 1); addr3 = 3'd1; in = 8'h3C;
      addr1 = 3'd0; addr2 = AW'(DEPTH - 1);
      push_reads();
      #2;
      for (int p = 0; p < 2; p++) begin
        got = (p == 0) ? {v1, z1} : {v2, z2};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL sweep cyc%0d port%0d got=%h exp=%h", c, p + 1, got, exp); end
      end
      checks++;
      if (busy !== m_busy) begin errors++; $display("FAIL sweep_busy cyc%0d got=%b exp=%b", c, busy, m_busy); end
      if (!busy) break;
      busy_cycles++;
      tick();
    end
    enable = 1'b0; clear = 1'b0;
    checks++;
    if (busy_cycles !== DEPTH) begin errors++; $display("FAIL sweep_len got=%0d exp=%0d", busy_cycles, DEPTH); end
    for (int a = 0; a < DEPTH; a++) begin
      addr1 = AW'(a); addr2 = AW'(DEPTH - 1 - a);
      push_reads();
      #2;
      for (int p = 0; p < 2; p++) begin
        got = (p == 0) ? {v1, z1} : {v2, z2};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL after_sweep addr=%0d port%0d got=%h exp=%h", a, p + 1, got, exp); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_sweep();
    enable = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin addr3 = AW'(a); in = N'(8'h40 + a); tick(); end
    enable = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0; addr1 = 3'd0; addr2 = 3'd4;
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    push_reads();
    for (int p = 0; p < 2; p++) begin
      got = (p == 0) ? {v1, z1} : {v2, z2};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL abort_read port%0d got=%h exp=%h", p + 1, got, exp); end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 2 * DEPTH; c++) begin
      addr1 = AW'(c % DEPTH); addr2 = AW'(DEPTH - 1);
      push_reads();
      #2;
      for (int p = 0; p < 2; p++) begin
        got = (p == 0) ? {v1, z1} : {v2, z2};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL resweep cyc%0d port%0d got=%h exp=%h", c, p + 1, got, exp); end
      end
      if (!busy) break;
      busy_cycles++;
      tick();
    end
    checks++;
    if (busy_cycles !== DEPTH) begin errors++; $display("FAIL resweep_len got=%0d exp=%0d", busy_cycles, DEPTH); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_out_of_range();
    test_random();
    test_back_to_back();
    test_sweep();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_clr.md
REGFILE_CLR -- requirements
Module: regfile_clr

Interface
REQ-001 SHALL have parameter N, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: number of entries, range 2..256, not necessarily a power of two.
REQ-003 SHALL have parameter AW, default $clog2(DEPTH): address width.
REQ-004 SHALL have port clock, input, 1: sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port in, input, N: write data.
REQ-007 SHALL have port addr1, input, AW: read port 1 address.
REQ-008 SHALL have port addr2, input, AW: read port 2 address.
REQ-009 SHALL have port addr3, input, AW: write address.
REQ-010 SHALL have port enable, input, 1: write request.
REQ-011 SHALL have port clear, input, 1: start-sweep request, sampled on a clock edge.
REQ-012 SHALL have ports z1 and z2, output, N each: read data for ports 1 and 2.
REQ-013 SHALL have ports v1 and v2, output, 1 each: entry-valid flags for ports 1 and 2.
REQ-014 SHALL have port busy, output, 1: high while a sweep is in progress.

Function
REQ-015 Reads SHALL be combinational: zK = M[addrK] when the entry is valid and addrK < DEPTH, else 0; vK = valid[addrK] under the same condition, else 0.
REQ-016 In IDLE, enable=1 with addr3 < DEPTH SHALL write in to M[addr3] and set valid[addr3] at the edge; enable with addr3 >= DEPTH SHALL be ignored.
REQ-017 FSM states SHALL be IDLE and SWEEP; IDLE->SWEEP on an edge with clear=1; SWEEP->IDLE on the edge that writes entry DEPTH-1.
REQ-018 In SWEEP, each edge SHALL write 0 to M[ptr], set valid[ptr] and increment ptr; ptr starts at 0, so a sweep takes exactly DEPTH cycles.
REQ-019 busy SHALL equal (state == SWEEP).
REQ-020 During SWEEP, enable and clear SHALL be ignored, with no queuing.
REQ-021 clear and enable asserted together in IDLE: the sweep SHALL start and the write SHALL be dropped.
REQ-022 Reads during SWEEP SHALL return current contents: swept entries read 0 with valid=1, unswept entries read old data.
REQ-023 Two read ports at the same address SHALL return identical data.

Reset
REQ-024 reset_n=0 SHALL immediately force state=IDLE, ptr=0 and all valid bits to 0, so z1=z2=0, v1=v2=0 and busy=0.
REQ-025 The data array SHALL NOT be reset, to allow RAM/LUT inference.
REQ-026 Reset during SWEEP SHALL abort the sweep; the entries already swept SHALL remain invalid after reset.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN defined: in IDLE with enable=1 and addr3 == addrK < DEPTH, zK SHALL equal in and vK SHALL be 1 in the same cycle (write-first forwarding).
REQ-028 Macro REGFILE_BYPASS_EN undefined: zK SHALL show pre-write content until after the edge (read-first).

Structure
REQ-029 Package regfile_pkg SHALL hold the FSM state enum (IDLE, SWEEP) and the default N/DEPTH constants.
REQ-030 The design SHALL be a single module; no sub-module is needed, and the read mux is inline.

Verification
REQ-031 Reset, then read addr1=3, addr2=5 -> z1=z2=0, v1=v2=0, busy=0.
REQ-032 Write 0xA5 to addr3=2, next cycle read addr1=2 -> z1=0xA5, v1=1; same-cycle read gives 0xA5 with bypass, prior value without.
REQ-033 Fill all entries with 0xFF, pulse clear -> busy high exactly DEPTH cycles; mid-sweep addr1=0 reads 0/v=1 and addr2=DEPTH-1 reads 0xFF; afterwards all entries read 0 with v=1.
REQ-034 During SWEEP assert enable with addr3=1, in=0x3C -> after the sweep, entry 1 reads 0.
REQ-035 DEPTH=6, write to addr3=7 -> no array change; read addr1=7 gives z1=0, v1=0.
REQ-036 Assert reset_n=0 at sweep cycle 3 -> busy drops asynchronously and all v=0; a subsequent clear runs a full DEPTH-cycle sweep.
